// File: rtl/step_pkg.sv
// step_pkg: shared debounce FSM states, display constants and the hex-to-7-segment helper.
package step_pkg;
    typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_HELD, S_REL_DB} step_state_t;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a per-bit reset value.
module sync_2ff #(
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= {RST_VAL, RST_VAL};
        else     {q, meta} <= {meta, d};
endmodule

// File: rtl/step_controller.sv
// step_controller: debounced single-step / free-run pipeline enable with step counter.
// Define STEP_CONTROLLER_SEG_EN to drive disp1 with the low hex digit of step_count.
module step_controller
    import step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_button,
    input  logic             step_enable,
    output logic             pipe_en,
    output logic             step_pulse,
    output logic [CNT_W-1:0] step_count,
    output logic [6:0]       disp1
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic btn_s, mode_s, ready, last, accept;
    logic [1:0] vld;
    logic [DW-1:0] cnt;
    step_state_t state;
    sync_2ff #(.W(2), .RST_VAL(2'b10)) u_sync (
        .clk(clk),
        .rst(rst),
        .d({step_button, step_enable}),
        .q({btn_s, mode_s})
    );
    assign last   = cnt == DW'(DEBOUNCE_CYCLES - 1);
    assign accept = state == S_PRESS_DB && !btn_s && last;
    // ready blocks new presses until the button is seen released after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            vld        <= '0;
            ready      <= 1'b0;
            pipe_en    <= 1'b0;
            step_pulse <= 1'b0;
            step_count <= '0;
        end else begin
            vld        <= {vld[0], 1'b1};
            ready      <= ready | (vld[1] & btn_s);
            pipe_en    <= vld[0] & (!mode_s | accept);
            step_pulse <= accept & mode_s;
            step_count <= step_count + CNT_W'(accept & mode_s);
            case (state)
                S_IDLE: if (ready && !btn_s) begin
                    state <= S_PRESS_DB;
                    cnt   <= '0;
                end
                S_PRESS_DB: begin
                    state <= btn_s ? S_IDLE : (last ? S_HELD : S_PRESS_DB);
                    cnt   <= cnt + 1'b1;
                end
                S_HELD: if (btn_s) begin
                    state <= S_REL_DB;
                    cnt   <= '0;
                end
                default: begin
                    state <= !btn_s ? S_HELD : (last ? S_IDLE : S_REL_DB);
                    cnt   <= cnt + 1'b1;
                end
            endcase
        end
    end
`ifdef STEP_CONTROLLER_SEG_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) disp1 <= SEG_OFF;
        else     disp1 <= hex_to_seg(4'(step_count));
`else
    assign disp1 = SEG_OFF;
`endif
endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller: directed checks of reset, stepping, debounce, mode switching and counter wrap.
module tb_step_controller;
    logic clk = 1'b0, rst = 1'b1, step_button = 1'b1, step_enable = 1'b0;
    logic pipe_en, step_pulse, pe2, sp2;
    logic [15:0] step_count;
    logic [1:0] cnt2;
    logic [6:0] disp1, disp2;
    int n_run = 0, n_fail = 0, exp_cnt = 0;
`ifdef STEP_CONTROLLER_SEG_EN
    localparam logic [6:0] SEG1 = 7'h79, SEG5 = 7'h12;
`else
    localparam logic [6:0] SEG1 = 7'h7F, SEG5 = 7'h7F;
`endif
    always #5 clk = ~clk;
    step_controller dut (
        .clk(clk), .rst(rst), .step_button(step_button), .step_enable(step_enable),
        .pipe_en(pipe_en), .step_pulse(step_pulse), .step_count(step_count), .disp1(disp1)
    );
    step_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .step_button(step_button), .step_enable(step_enable),
        .pipe_en(pe2), .step_pulse(sp2), .step_count(cnt2), .disp1(disp2)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic press(input string tag, input int low, input int high, input int exp_p);
        int np = 0, lat = 0, bad = 0;
        for (int i = 0; i < low + high; i++) begin
            step_button = (i < low) ? 1'b0 : 1'b1;
            tick();
            if (step_pulse) begin
                np++;
                if (lat == 0) lat = i + 1;
            end
            if (step_enable ? (pipe_en !== step_pulse) : (pipe_en !== 1'b1)) bad++;
        end
        check({tag, " pulses"}, np, exp_p);
        if (exp_p == 1) check({tag, " latency"}, lat, 7);
        check({tag, " pipe_en"}, bad, 0);
        if (step_enable) exp_cnt += exp_p;
        check({tag, " count"}, step_count, exp_cnt);
        check({tag, " count2"}, cnt2, exp_cnt % 4);
    endtask
    initial begin
        int np;
        repeat (2) tick();
        check("rst pipe_en", pipe_en, 0);
        check("rst step_pulse", step_pulse, 0);
        check("rst count", step_count, 0);
        check("rst disp1", disp1, 7'h7F);
        rst = 1'b0;
        tick();
        check("pe edge1", pipe_en, 0);
        tick();
        check("pe edge2", pipe_en, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("pe run", pipe_en, 1);
        end
        step_enable = 1'b1;
        repeat (4) tick();
        check("pe step idle", pipe_en, 0);
        press("clean", 10, 10, 1);
        check("clean disp1", disp1, SEG1);
        press("bounce_a", 2, 1, 0);
        press("bounce_b", 2, 10, 0);
        press("bounce_long", 8, 10, 1);
        step_enable = 1'b0;
        repeat (4) tick();
        check("pe back to run", pipe_en, 1);
        press("run_hold", 10, 0, 0);
        step_enable = 1'b1;
        np = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            np += int'(step_pulse);
        end
        check("switch held pulses", np, 0);
        check("switch held pe", pipe_en, 0);
        press("held_rel", 0, 6, 0);
        press("after_switch", 10, 10, 1);
        step_button = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("midrst pipe_en", pipe_en, 0);
        check("midrst count", step_count, 0);
        check("midrst disp1", disp1, 7'h7F);
        exp_cnt = 0;
        repeat (2) tick();
        rst = 1'b0;
        np = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            np += int'(step_pulse);
        end
        check("midrst held pulses", np, 0);
        press("midrst_rel", 0, 10, 0);
        press("midrst_new", 10, 10, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) press("wrap", 10, 10, 1);
        check("wrap disp2", disp2, SEG1);
        check("wrap disp1", disp1, SEG5);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Upstream control stage for pipeline_top: converts the raw board step push-button and the step/run mode switch into a clean pipeline-advance enable.
- Run mode: enable held high, so the pipeline free-runs.
- Step mode: each debounced button press yields exactly one single-cycle enable pulse, advancing the pipeline by one clock.
- Also keeps a step counter and optionally drives a 7-segment digit.

Parameters:
- DEBOUNCE_CYCLES, 4, stable cycles required to accept a press or release (board build overrides to 500000).
- CNT_W, 16, width of step_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- step_button  in  1  raw push-button, active-low (idle = 1), asynchronous to clk.
- step_enable  in  1  raw mode switch, asynchronous: 1 = step mode, 0 = run mode.
- pipe_en  out  1  pipeline advance enable to pipeline_top.
- step_pulse  out  1  one-cycle strobe per accepted press in step mode.
- step_count  out  CNT_W  number of accepted steps since reset.
- disp1  out  7  7-segment pattern, active-low segments {g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, rst=1), all values forced immediately:
  - synchronizer flops: button = 1, mode = 0.
  - FSM = S_IDLE, debounce counter = 0.
  - pipe_en = 0, step_pulse = 0, step_count = 0, disp1 = 7'h7F.
- Synchronization: 2-FF synchronizers on step_button and step_enable; all logic below uses the synced versions btn_s and mode_s.
- Debounce FSM, counter width $clog2(DEBOUNCE_CYCLES+1):
  - S_IDLE: btn_s=0 -> S_PRESS_DB, counter cleared.
  - S_PRESS_DB: counter increments while btn_s=0.
    - btn_s=1 before counter reaches DEBOUNCE_CYCLES -> S_IDLE, no pulse.
    - Counter reaches DEBOUNCE_CYCLES -> S_HELD; press accepted.
  - S_HELD: btn_s=1 -> S_REL_DB, counter cleared.
  - S_REL_DB: counter increments while btn_s=1.
    - btn_s=0 -> S_HELD.
    - Counter reaches DEBOUNCE_CYCLES -> S_IDLE.
- Press acceptance and latency:
  - A press is accepted on the S_PRESS_DB -> S_HELD edge.
  - If mode_s=1 on that edge, step_pulse and pipe_en are both registered high for exactly the following cycle.
  - Latency: first raw low sampled at edge k -> step_pulse high in the cycle after edge k+2+DEBOUNCE_CYCLES (k+6 at default).
- pipe_en:
  - Registered.
  - mode_s=0: pipe_en=1 every cycle after reset release, starting from the second edge after rst deasserts.
  - mode_s=1: pipe_en = step_pulse.
- Mode changes:
  - Run -> step: pipe_en drops to 0 on the edge after mode_s goes 1.
  - Step -> run: pipe_en rises on the edge after mode_s goes 0.
- Presses in run mode are still debounced but produce no step_pulse and no count.
- Entering step mode while in S_HELD gives no pulse; a full release plus a new press is required.
- step_count:
  - Increments by 1 in the same cycle step_pulse is high.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - Never changes in run mode.
- Reset mid-press (any state) discards the press: no pulse after reset release until btn_s is seen high and then a new press is debounced.

Optional Feature:
- Macro: STEP_CONTROLLER_SEG_EN.
- Defined: disp1 registered = hex 7-seg encoding of step_count[3:0], active-low. Examples: 0 -> 7'h40, 1 -> 7'h79, A -> 7'h08. Updates one cycle after step_count changes.
- Undefined: disp1 tied to 7'h7F (all segments off); no decoder logic synthesized.

Decomposition:
- Shared package step_pkg:
  - typedef enum logic [1:0] step_state_t {S_IDLE, S_PRESS_DB, S_HELD, S_REL_DB}.
  - localparam SEG_OFF = 7'h7F.
  - function hex_to_seg(logic [3:0]) returning logic [6:0].
- One sub-module: sync_2ff (parameterized width); instantiated once with width 2 for button and mode.

Test Plan:
- Reset: rst=1 for 20 ns -> pipe_en=0, step_pulse=0, step_count=0, disp1=7'h7F during reset. Release with step_enable=0 -> pipe_en=1 from the second edge after release, and stays 1.
- Clean step: step_enable=1; hold step_button=0 for 10 cycles, then 1 -> exactly one step_pulse/pipe_en cycle, 6 cycles after first low sample; step_count=1.
- Bounce: step_enable=1; step_button low 2 cycles, high 1, low 2, high -> no pulse, step_count stays 0. Repeat with low 8 cycles -> one pulse.
- Mode switch while held: step_enable=0, press and hold, set step_enable=1 -> no pulse. Release 6 cycles and press again -> one pulse.
- Wrap and display: CNT_W=2, STEP_CONTROLLER_SEG_EN defined, 5 clean presses -> step_count sequence 1,2,3,0,1; disp1 ends at 7'h79.
- Reset mid-press: assert rst during S_PRESS_DB with button held low, release rst with button still low -> no pulse until the button goes high, then a new press is debounced.
